// File: rtl/multi_operand_accumulator_if.sv
// multi_operand_accumulator_if: valid/ready bundle for the multi-operand accumulator.
// Input side carries the operand vector plus Mode/Clr sidebands. Output side carries
// the sum and the sticky overflow flag.
interface multi_operand_accumulator_if #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int OW = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0][W-1:0]   in_data;
    logic                  mode;
    logic                  clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         out_sum;
    logic                  overflow;

    modport master (
        output in_valid, in_data, mode, clr, out_ready,
        input  in_ready, out_valid, out_sum, overflow
    );

    modport slave (
        input  in_valid, in_data, mode, clr, out_ready,
        output in_ready, out_valid, out_sum, overflow
    );
endinterface

// File: rtl/multi_operand_accumulator.sv
// multi_operand_accumulator: pipelined N-operand adder tree with an optional running
// accumulator and stall-all valid/ready flow control.
// Stages: operand capture, log2(N) registered tree levels, registered final stage.
// Build option MOA_SATURATE_EN: Mode 1 results clamp to all-ones on overflow
// instead of wrapping.

// One registered pair-adder node of the reduction tree.
module moa_node #(
    parameter int OW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [OW-1:0] a,
    input  logic [OW-1:0] b,
    output logic [OW-1:0] sum
);
    // Register the pair sum; hold while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sum <= '0;
        else if (en) sum <= a + b;
    end
endmodule

module multi_operand_accumulator #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int OW = 32
) (
    input  logic clk,
    input  logic rst_n,
    multi_operand_accumulator_if.slave bus
);
    localparam int L = $clog2(N);

    logic                 en;
    logic [N-1:0][OW-1:0] leaf;      // zero-extended operands, stage 0
    logic [N-1:1][OW-1:0] sum_node;  // heap-ordered tree, node 1 is the root
    logic [L:0]           vld_pipe;
    logic [L:0]           mode_pipe;
    logic [L:0]           clr_pipe;
    logic [OW-1:0]        acc;
    logic [OW-1:0]        base;
    logic [OW:0]          s;
    logic [OW-1:0]        acc_sum;

    // Stall-all: everything advances only when the output register can move.
    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // Capture operands (zero-extended) and the valid/sideband bits at entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf      <= '0;
            vld_pipe  <= '0;
            mode_pipe <= '0;
            clr_pipe  <= '0;
        end else if (en) begin
            for (int k = 0; k < N; k++) leaf[k] <= OW'(bus.in_data[k]);
            vld_pipe  <= {vld_pipe[L-1:0],  bus.in_valid};
            mode_pipe <= {mode_pipe[L-1:0], bus.mode};
            clr_pipe  <= {clr_pipe[L-1:0],  bus.clr};
        end
    end

    // Node i sums children 2i and 2i+1; children at index >= N are leaves.
    // All leaves sit at the same depth, so every node index lands on one level.
    for (genvar i = 1; i < N; i++) begin : g_node
        if (2 * i >= N) begin : g_leaf_pair
            moa_node #(.OW(OW)) u_node (
                .clk(clk), .rst_n(rst_n), .en(en),
                .a(leaf[2*i-N]), .b(leaf[2*i+1-N]), .sum(sum_node[i])
            );
        end else begin : g_inner_pair
            moa_node #(.OW(OW)) u_node (
                .clk(clk), .rst_n(rst_n), .en(en),
                .a(sum_node[2*i]), .b(sum_node[2*i+1]), .sum(sum_node[i])
            );
        end
    end

    // Accumulate path: one carry bit beyond OW detects overflow.
    always_comb begin
        base = clr_pipe[L] ? '0 : acc;
        s    = {1'b0, base} + {1'b0, sum_node[1]};
`ifdef MOA_SATURATE_EN
        acc_sum = s[OW] ? '1 : s[OW-1:0];
`else
        acc_sum = s[OW-1:0];
`endif
    end

    // Final stage: bubbles advance out_valid but never touch acc/sum/overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.overflow  <= 1'b0;
            acc           <= '0;
        end else if (en) begin
            bus.out_valid <= vld_pipe[L];
            if (vld_pipe[L]) begin
                if (mode_pipe[L]) begin
                    bus.out_sum  <= acc_sum;
                    acc          <= acc_sum;
                    bus.overflow <= (bus.overflow && !clr_pipe[L]) || s[OW];
                end else begin
                    bus.out_sum <= sum_node[1];
                    acc         <= sum_node[1];
                    if (clr_pipe[L]) bus.overflow <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Scoreboard bench: drivers push expected results when a transfer is accepted,
// monitors pop and compare on every output handshake.
module tb_multi_operand_accumulator;
    localparam int N    = 16;
    localparam int W    = 8;
    localparam int OW   = 32;
    localparam int OW12 = 12;

`ifdef MOA_SATURATE_EN
    localparam logic [31:0] OVF12 = 32'hFFF;
`else
    localparam logic [31:0] OVF12 = 32'hFE0;
`endif

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct packed { logic [31:0] sum; logic ovf; } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_operand_accumulator_if #(.N(N), .W(W), .OW(OW))   b();
    multi_operand_accumulator_if #(.N(N), .W(W), .OW(OW12)) b12();

    multi_operand_accumulator #(.N(N), .W(W), .OW(OW))   dut   (.clk(clk), .rst_n(rst_n), .bus(b));
    multi_operand_accumulator #(.N(N), .W(W), .OW(OW12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    exp_t q[$];
    exp_t q12[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t fill(input logic [W-1:0] x);
        vec_t r;
        for (int k = 0; k < N; k++) r[k] = x;
        return r;
    endfunction

    // Monitor for the default-width instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b.out_valid && b.out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon32_extra: got 0x%0h expected no output", b.out_sum);
            end else begin
                e = q.pop_front();
                check("mon32_sum", b.out_sum, e.sum);
                check("mon32_ovf", 32'(b.overflow), 32'(e.ovf));
            end
        end
    end

    // Monitor for the OW=12 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b12.out_valid && b12.out_ready) begin
            if (q12.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon12_extra: got 0x%0h expected no output", b12.out_sum);
            end else begin
                e = q12.pop_front();
                check("mon12_sum", 32'(b12.out_sum), e.sum);
                check("mon12_ovf", 32'(b12.overflow), 32'(e.ovf));
            end
        end
    end

    // Drive one transfer on the default instance; push expectation on acceptance.
    task automatic send(input vec_t d, input logic m, input logic c,
                        input logic [31:0] es, input logic eo, input bit push);
        bit ok = 0;
        b.in_data = d; b.mode = m; b.clr = c; b.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = b.in_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send32_timeout: got in_ready=0 expected 1");
        end else if (push) begin
            q.push_back('{sum: es, ovf: eo});
        end
        #1 b.in_valid = 1'b0;
    endtask

    task automatic send12(input vec_t d, input logic m, input logic c,
                          input logic [31:0] es, input logic eo);
        bit ok = 0;
        b12.in_data = d; b12.mode = m; b12.clr = c; b12.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = b12.in_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send12_timeout: got in_ready=0 expected 1");
        end else begin
            q12.push_back('{sum: es, ovf: eo});
        end
        #1 b12.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && q12.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (q.size() != 0 || q12.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q.size(), q12.size());
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   lat;
        b.in_valid = 0;   b.in_data = '0;   b.mode = 0;   b.clr = 0;   b.out_ready = 1;
        b12.in_valid = 0; b12.in_data = '0; b12.mode = 0; b12.clr = 0; b12.out_ready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(b.out_valid), 0);
        check("rst_out_sum",   b.out_sum, 0);
        check("rst_overflow",  32'(b.overflow), 0);
        check("rst_in_ready",  32'(b.in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // All 0xFF, Mode 0, plus latency
        send(fill(8'hFF), 0, 0, 32'h0000_0FF0, 0, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b.out_valid) begin lat = i; break; end
        end
        check("latency", 32'(lat), 32'd5);
        drain();

        // Single lane 10, then k+1 per lane
        v = '0; v[10] = 8'h01;
        send(v, 0, 0, 32'h1, 0, 1);
        for (int k = 0; k < N; k++) v[k] = W'(k + 1);
        send(v, 0, 0, 32'h88, 0, 1);
        drain();

        // Four vectors with a 3-cycle downstream stall after the first result
        fork
            begin
                for (int i = 0; i < 4; i++) send(fill(8'h01), 0, 0, 32'h10, 0, 1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    if (b.out_valid) break;
                end
                b.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready",  32'(b.in_ready), 0);
                    check("stall_out_valid", 32'(b.out_valid), 1);
                    check("stall_out_sum",   b.out_sum, 32'h10);
                end
                @(posedge clk); #1 b.out_ready = 1'b1;
            end
        join
        drain();

        // OW=12 overflow sequence
        send12(fill(8'hFF), 1, 1, 32'hFF0, 0);
        send12(fill(8'hFF), 1, 0, OVF12,   1);
        send12(fill(8'hFF), 1, 1, 32'hFF0, 0);
        send12(fill(8'hFF), 1, 0, OVF12,   1);
        send12(fill(8'hFF), 0, 0, 32'hFF0, 1);
        send12(fill(8'hFF), 0, 1, 32'hFF0, 0);
        drain();

        // Build Acc = 0x30, put 3 vectors in flight, pulse reset
        send(fill(8'h01), 1, 1, 32'h10, 0, 1);
        send(fill(8'h01), 1, 0, 32'h20, 0, 1);
        send(fill(8'h01), 1, 0, 32'h30, 0, 1);
        drain();
        for (int i = 0; i < 3; i++) send(fill(8'h01), 1, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", 32'(b.out_valid), 0);
        check("rst2_out_sum",   b.out_sum, 0);
        check("rst2_overflow",  32'(b.overflow), 0);
        check("rst2_in_ready",  32'(b.in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("rst2_no_ghost", 32'(b.out_valid), 0);
        send(fill(8'h01), 1, 0, 32'h10, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
